inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder and injector: accepts structured micro-op commands (operation class, register indices, immediate), encodes them into RV32I instruction words, and queues them for the core's decode stage. It is the producer-side counterpart of the control unit's field extraction, used for debug program-buffer injection and self-test instruction streams. Pseudo-op LI expands into a LUI/ADDI pair. Out-of-range immediates are flagged and dropped.

## Interface
- INST_WIDTH, 32, instruction word width (only 32 supported)
- FIFO_DEPTH, 4, output queue depth in instructions (power of two, >=2)

- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  4  command class: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, LI, NOP, ECALL
- cmd_rd / cmd_rs1 / cmd_rs2  in  5 each  register indices
- cmd_funct3  in  3  funct3 field (R/I/LOAD/STORE/BRANCH)
- cmd_alt  in  1  sets funct7[5] (SUB/SRA/SRAI)
- cmd_imm  in  32  signed immediate (byte offset for BRANCH/JAL; full value for LI; imm[31:12] payload for LUI/AUIPC)
- inst_out  out  INST_WIDTH  head-of-queue instruction; 0 when empty
- inst_valid  out  1  queue non-empty
- inst_ready  in  1  consumer takes inst_out when inst_valid && inst_ready
- illegal  out  1  one-cycle pulse: accepted command was dropped
- busy  out  1  LI expansion in progress or queue non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued instruction count

## Operation
- Field placement: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- I/LOAD/JALR: imm must lie in [-2048,2047]; imm[11:0] -> [31:20].
- I with funct3 001/101: imm[31:5] must be 0; [31:25] = {0,cmd_alt,00000}, [24:20]=imm[4:0]. Other I funct3 ignore cmd_alt.
- STORE: [-2048,2047]; split imm[11:5]/imm[4:0].
- BRANCH: [-4096,4094], imm[0]=0; B scatter. funct3 010/011 illegal.
- JAL: [-1048576,1048574], imm[0]=0; J scatter. JALR/LOAD/STORE funct3 not checked.
- LUI/AUIPC: imm[31:12] -> [31:12], imm[11:0] ignored.
- NOP = 0x00000013; ECALL = 0x00000073; registers/imm ignored.
- LI: if imm in [-2048,2047] emit ADDI rd,x0,imm. Else hi=(imm+0x800)>>12 (32-bit wrap), emit LUI rd,hi; if imm[11:0]!=0 also emit ADDI rd,rd,imm[11:0].
- Illegal (range, alignment, reserved funct3, undefined cmd_op): command consumed, illegal pulses next cycle, nothing queued.
- FSM: IDLE -> EXPAND when LI needs two words (LUI pushed on accept); EXPAND pushes ADDI when queue not full -> IDLE. cmd_ready=0 in EXPAND.
- cmd_ready = (state==IDLE) && (fifo_count<FIFO_DEPTH); a pop in the same cycle does not raise cmd_ready at full.

## Timing
- Reset values: cmd_ready 1, inst_out 0, inst_valid 0, illegal 0, busy 0, fifo_count 0, state IDLE.
- Latency: command accepted in cycle N -> first word on inst_out with inst_valid in N+1; LI second word queued N+1 if space, visible N+2.
- Simultaneous push and pop: count unchanged, order preserved.
- inst_out/inst_valid stable while inst_valid && !inst_ready.
- Reset mid-expansion: pending ADDI discarded, queue flushed, outputs to reset values within the same cycle.

## Structure
- Package enc_pkg: cmd_op enum, RV32I opcode constants (shared with control unit), NOP/ECALL words, immediate range constants.
- Sub-module inst_fifo (parameter DEPTH, WIDTH; push/pop/count/head, async reset).
- Encoding and legality checks: one combinational function per format in enc_pkg.

## Test plan
- R, rd=3 rs1=1 rs2=2 funct3=0 alt=0 -> 0x002081B3 next cycle; alt=1 -> 0x402081B3.
- LI rd=5 imm=0x12345FFF -> 0x123462B7 then 0xFFF28293; cmd_ready low one cycle. LI rd=5 imm=0x00001000 -> only LUI 0x000012B7. LI imm=-1 -> 0xFFF00293.
- BRANCH funct3=0 imm=3 -> illegal pulse, fifo_count stays 0; imm=4096 -> illegal; imm=-4096 rs1=1 rs2=2 -> 0x80208063.
- inst_ready=0, five NOP commands -> four queued (fifo_count=4), cmd_ready 0, fifth stalled; raise inst_ready -> five 0x00000013 in order.
- I funct3=101 alt=1 imm=3 rd=1 rs1=2 -> 0x40315093; imm=32 -> illegal.
- LI two-word, rst asserted in EXPAND, inst_ready=0 -> after reset inst_valid=0, fifo_count=0, no ADDI ever emitted.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared RV32I encoding definitions: command classes, opcodes, immediate ranges
// and per-format encode/legality functions used by the instruction injector.
package enc_pkg;

  typedef enum logic [3:0] {
    OP_R      = 4'd0,
    OP_I      = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_JAL    = 4'd5,
    OP_JALR   = 4'd6,
    OP_LUI    = 4'd7,
    OP_AUIPC  = 4'd8,
    OP_LI     = 4'd9,
    OP_NOP    = 4'd10,
    OP_ECALL  = 4'd11
  } cmd_op_e;

  typedef enum logic {ST_IDLE, ST_EXPAND} enc_state_e;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

  function automatic enc_t enc_r(input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                                 input logic alt);
    enc_t r;
    r.ok   = 1'b1;
    r.word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
    return r;
  endfunction

  // Shift-immediates carry shamt plus funct7; everything else is a plain 12-bit I immediate.
  function automatic enc_t enc_i(input logic [6:0] opc, input logic [4:0] rd, rs1,
                                 input logic [2:0] f3, input logic alt, input logic [31:0] imm);
    enc_t r;
    if (opc == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
      r.ok   = (imm[31:5] == '0);
      r.word = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, opc};
    end else begin
      r.ok   = in_range(imm, IMM12_MIN, IMM12_MAX);
      r.word = {imm[11:0], rs1, f3, rd, opc};
    end
    return r;
  endfunction

  function automatic enc_t enc_s(input logic [4:0] rs1, rs2, input logic [2:0] f3,
                                 input logic [31:0] imm);
    enc_t r;
    r.ok   = in_range(imm, IMM12_MIN, IMM12_MAX);
    r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    return r;
  endfunction

  function automatic enc_t enc_b(input logic [4:0] rs1, rs2, input logic [2:0] f3,
                                 input logic [31:0] imm);
    enc_t r;
    r.ok   = in_range(imm, IMMB_MIN, IMMB_MAX) && !imm[0] &&
             (f3 != 3'b010) && (f3 != 3'b011);
    r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    return r;
  endfunction

  function automatic enc_t enc_j(input logic [4:0] rd, input logic [31:0] imm);
    enc_t r;
    r.ok   = in_range(imm, IMMJ_MIN, IMMJ_MAX) && !imm[0];
    r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    return r;
  endfunction

  function automatic enc_t enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                 input logic [19:0] imm_hi);
    enc_t r;
    r.ok   = 1'b1;
    r.word = {imm_hi, rd, opc};
    return r;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Command and instruction-stream bundle between a micro-op producer and inst_encoder.
interface inst_encoder_if #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [3:0]                    cmd_op;
  logic [4:0]                    cmd_rd;
  logic [4:0]                    cmd_rs1;
  logic [4:0]                    cmd_rs2;
  logic [2:0]                    cmd_funct3;
  logic                          cmd_alt;
  logic [31:0]                   cmd_imm;
  logic [INST_WIDTH-1:0]         inst_out;
  logic                          inst_valid;
  logic                          inst_ready;
  logic                          illegal;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_alt, cmd_imm,
    input  cmd_ready,
    input  inst_out, inst_valid,
    output inst_ready,
    input  illegal, busy, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_alt, cmd_imm,
    output cmd_ready,
    output inst_out, inst_valid,
    input  inst_ready,
    output illegal, busy, fifo_count
  );
endinterface

// File: rtl/inst_fifo.sv
// Power-of-two instruction queue; head reads 0 while empty, pointers wrap naturally.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/inst_encoder.sv
// Encodes micro-op commands into RV32I words and queues them; LI may expand to LUI+ADDI,
// with the ADDI held in a pending register until the queue has room.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  inst_encoder_if.slave bus
);
  enc_state_e             state, state_nxt;
  cmd_op_e                op;
  enc_t                   enc;
  logic [31:0]            second_word;
  logic [31:0]            pend_word;
  logic                   need_two;
  logic                   accept;
  logic                   push;
  logic [INST_WIDTH-1:0]  push_data;
  logic                   full;
  logic                   empty;
  logic                   illegal_q;
  logic [19:0]            li_hi;

  assign op     = cmd_op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  // (imm + 0x800) >> 12 reduces to rounding the upper 20 bits by imm[11].
  assign li_hi = bus.cmd_imm[31:12] + {19'b0, bus.cmd_imm[11]};

  always_comb begin
    enc         = '0;
    second_word = '0;
    need_two    = 1'b0;
    case (op)
      OP_R:      enc = enc_r(bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2, bus.cmd_funct3, bus.cmd_alt);
      OP_I:      enc = enc_i(OPC_OP_IMM, bus.cmd_rd, bus.cmd_rs1, bus.cmd_funct3, bus.cmd_alt,
                             bus.cmd_imm);
      OP_LOAD:   enc = enc_i(OPC_LOAD, bus.cmd_rd, bus.cmd_rs1, bus.cmd_funct3, 1'b0, bus.cmd_imm);
      OP_JALR:   enc = enc_i(OPC_JALR, bus.cmd_rd, bus.cmd_rs1, bus.cmd_funct3, 1'b0, bus.cmd_imm);
      OP_STORE:  enc = enc_s(bus.cmd_rs1, bus.cmd_rs2, bus.cmd_funct3, bus.cmd_imm);
      OP_BRANCH: enc = enc_b(bus.cmd_rs1, bus.cmd_rs2, bus.cmd_funct3, bus.cmd_imm);
      OP_JAL:    enc = enc_j(bus.cmd_rd, bus.cmd_imm);
      OP_LUI:    enc = enc_u(OPC_LUI, bus.cmd_rd, bus.cmd_imm[31:12]);
      OP_AUIPC:  enc = enc_u(OPC_AUIPC, bus.cmd_rd, bus.cmd_imm[31:12]);
      OP_NOP:    enc = '{ok: 1'b1, word: NOP_WORD};
      OP_ECALL:  enc = '{ok: 1'b1, word: ECALL_WORD};
      OP_LI: begin
        if (in_range(bus.cmd_imm, IMM12_MIN, IMM12_MAX)) begin
          enc = enc_i(OPC_OP_IMM, bus.cmd_rd, 5'd0, 3'b000, 1'b0, bus.cmd_imm);
        end else begin
          enc         = enc_u(OPC_LUI, bus.cmd_rd, li_hi);
          need_two    = (bus.cmd_imm[11:0] != '0);
          second_word = {bus.cmd_imm[11:0], bus.cmd_rd, 3'b000, bus.cmd_rd, OPC_OP_IMM};
        end
      end
      default:   enc = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = enc.word;
    case (state)
      ST_IDLE: begin
        if (accept && enc.ok) begin
          push = 1'b1;
          if (need_two) state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        push_data = pend_word;
        if (!full) begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pend_word <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= accept && !enc.ok;
      if (accept && enc.ok && need_two) pend_word <= second_word;
    end
  end

  inst_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INST_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.inst_ready),
    .head      (bus.inst_out),
    .count     (bus.fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.cmd_ready  = (state == ST_IDLE) && !full;
  assign bus.inst_valid = !empty;
  assign bus.illegal    = illegal_q;
  assign bus.busy       = (state == ST_EXPAND) || !empty;
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed commands push hand-computed words,
// a negedge monitor pops and compares every word the consumer takes.
module tb_inst_encoder;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_q[$];

  inst_encoder_if #(.INST_WIDTH(32), .FIFO_DEPTH(4)) bus ();

  inst_encoder #(.INST_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input cmd_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                           input logic [31:0] imm);
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_rs1    = rs1;
    bus.cmd_rs2    = rs2;
    bus.cmd_funct3 = f3;
    bus.cmd_alt    = alt;
    bus.cmd_imm    = imm;
    bus.cmd_valid  = 1'b1;
  endtask

  // Returns at posedge+1 of the cycle after acceptance.
  task automatic wait_accept();
    int unsigned n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=cmd_ready_high");
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input cmd_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                      input logic [31:0] imm);
    drive_cmd(op, rd, rs1, rs2, f3, alt, imm);
    wait_accept();
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!rst && bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h expected=none", bus.inst_out);
        end else begin
          w = exp_q.pop_front();
          check("scoreboard_word", bus.inst_out, w);
        end
      end
    end
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_funct3 = '0;
    bus.cmd_alt    = 1'b0;
    bus.cmd_imm    = '0;
    bus.inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cmd_ready",  {31'b0, bus.cmd_ready},  32'd1);
    check("rst_inst_out",   bus.inst_out,            32'd0);
    check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_illegal",    {31'b0, bus.illegal},    32'd0);
    check("rst_busy",       {31'b0, bus.busy},       32'd0);
    check("rst_fifo_count", {29'b0, bus.fifo_count}, 32'd0);

    bus.inst_ready = 1'b1;

    exp_q.push_back(32'h002081B3);
    send(OP_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
    check("r_latency_valid", {31'b0, bus.inst_valid}, 32'd1);
    exp_q.push_back(32'h402081B3);
    send(OP_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
    drain();

    exp_q.push_back(32'h123462B7);
    exp_q.push_back(32'hFFF28293);
    send(OP_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345FFF);
    check("li_expand_ready_low", {31'b0, bus.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("li_expand_ready_back", {31'b0, bus.cmd_ready}, 32'd1);
    drain();

    exp_q.push_back(32'h000012B7);
    send(OP_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h00001000);
    check("li_lui_only_ready", {31'b0, bus.cmd_ready}, 32'd1);
    exp_q.push_back(32'hFFF00293);
    send(OP_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFFFFF);
    drain();

    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3);
    check("br_misalign_illegal", {31'b0, bus.illegal},    32'd1);
    check("br_misalign_count",   {29'b0, bus.fifo_count}, 32'd0);
    @(posedge clk); #1;
    check("illegal_one_cycle",   {31'b0, bus.illegal},    32'd0);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd4096);
    check("br_range_illegal",    {31'b0, bus.illegal},    32'd1);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8);
    check("br_funct3_illegal",   {31'b0, bus.illegal},    32'd1);
    exp_q.push_back(32'h80208063);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFFF000);
    check("br_legal_no_illegal", {31'b0, bus.illegal},    32'd0);

    exp_q.push_back(32'h40315093);
    send(OP_I, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd3);
    send(OP_I, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd32);
    check("srai_shamt_illegal", {31'b0, bus.illegal}, 32'd1);
    exp_q.push_back(32'hFE312E23);
    send(OP_STORE, 5'd0, 5'd2, 5'd3, 3'b010, 1'b0, 32'hFFFFFFFC);
    exp_q.push_back(32'h001000EF);
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
    exp_q.push_back(32'hABCDE397);
    send(OP_AUIPC, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 32'hABCDE123);
    exp_q.push_back(32'h00000073);
    send(OP_ECALL, 5'd9, 5'd9, 5'd9, 3'b111, 1'b1, 32'h12345678);
    send(cmd_op_e'(4'hF), 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0);
    check("undef_op_illegal", {31'b0, bus.illegal}, 32'd1);
    drain();

    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(NOP_WORD);
      send(OP_NOP, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
    end
    drive_cmd(OP_NOP, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("full_count",      {29'b0, bus.fifo_count}, 32'd4);
    check("full_cmd_ready",  {31'b0, bus.cmd_ready},  32'd0);
    check("stall_inst_out",  bus.inst_out,            NOP_WORD);
    check("stall_valid",     {31'b0, bus.inst_valid}, 32'd1);
    exp_q.push_back(NOP_WORD);
    bus.inst_ready = 1'b1;
    wait_accept();
    drain();

    bus.inst_ready = 1'b0;
    send(OP_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345FFF);
    check("pre_rst_expand", {31'b0, bus.cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("midrst_inst_out",   bus.inst_out,            32'd0);
    check("midrst_fifo_count", {29'b0, bus.fifo_count}, 32'd0);
    check("midrst_cmd_ready",  {31'b0, bus.cmd_ready},  32'd1);
    check("midrst_busy",       {31'b0, bus.busy},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_addi", {31'b0, bus.inst_valid}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
